// File: rtl/status_telemetry_tx.sv
// status_telemetry_tx
// Serialises a 7-byte home-status frame (SOF, seq, temperature, window/door,
// person/status-high, status-low, XOR checksum) into a byte-wide UART TX.
// Frames are started by a host request, a periodic tick or a rising alert.
// Triggers that cannot be served at once are held in a one-deep pending bit.
module status_telemetry_tx #(
    parameter int unsigned PERIOD_CYCLES  = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter logic [7:0]  SOF            = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       req_i,
    input  logic [7:0] temperature_i,
    input  logic [3:0] window_i,
    input  logic [3:0] door_i,
    input  logic [3:0] person_i,
    input  logic [5:0] status_i,
    output logic       tx_send_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_done_i,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       timeout_o,
    output logic [7:0] seq_o
);

    localparam logic [31:0] LP_PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] LP_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_period_cnt;
    logic        w_tick;
    logic        r_alert_prev;
    logic        w_alert_rise;
    logic        w_trigger;

    logic        r_pending;
    logic        w_pending_next;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic [2:0]  w_idx_inc;
    logic [31:0] r_wait_cnt;
    logic [31:0] w_wait_cnt_next;
    logic [7:0]  r_seq;
    logic [7:0]  w_seq_next;
    logic [7:0]  r_tx_data;
    logic [7:0]  w_tx_data_next;
    logic        r_frame_done;
    logic        w_frame_done_next;
    logic        w_timeout;
    logic        w_capture;

    // Frame snapshot, frozen on the edge that leaves IDLE
    logic [7:0]  r_snap_seq;
    logic [7:0]  r_snap_temp;
    logic [3:0]  r_snap_win;
    logic [3:0]  r_snap_door;
    logic [3:0]  r_snap_person;
    logic [5:0]  r_snap_status;

    logic [7:0]  w_frame [0:7];
    logic [7:0]  w_csum;

    genvar gi;

    assign w_tick       = (r_period_cnt == LP_PERIOD_LAST);
    assign w_alert_rise = status_i[1] & ~r_alert_prev;
    assign w_trigger    = req_i | w_tick | w_alert_rise;
    assign w_idx_inc    = r_idx + 3'd1;

    // Frame bytes built from the snapshot; entry 7 is never addressed
    assign w_frame[0] = SOF;
    assign w_frame[1] = r_snap_seq;
    assign w_frame[2] = r_snap_temp;
    assign w_frame[3] = {r_snap_win, r_snap_door};
    assign w_frame[4] = {r_snap_person, r_snap_status[5:2]};
    assign w_frame[5] = {6'b0, r_snap_status[1:0]};
    assign w_frame[6] = w_csum;
    assign w_frame[7] = 8'h00;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_csum
            assign w_csum[gi] = w_frame[1][gi] ^ w_frame[2][gi] ^ w_frame[3][gi]
                              ^ w_frame[4][gi] ^ w_frame[5][gi];
        end
    endgenerate

    // Free-running period counter, independent of enable_i
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_cnt <= '0;
        end else if (w_tick) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 32'd1;
        end
    end

    // Next-state, pending merge, byte sequencing and wait timeout
    always_comb begin
        w_state_next      = r_state;
        w_pending_next    = r_pending | w_trigger;
        w_idx_next        = r_idx;
        w_wait_cnt_next   = r_wait_cnt;
        w_seq_next        = r_seq;
        w_tx_data_next    = r_tx_data;
        w_frame_done_next = 1'b0;
        w_timeout         = 1'b0;
        w_capture         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i && (w_trigger || r_pending)) begin
                    w_capture      = 1'b1;
                    w_idx_next     = 3'd0;
                    w_pending_next = 1'b0;
                    w_tx_data_next = SOF;
                    w_state_next   = ST_SEND;
                end
            end
            ST_SEND: begin
                w_wait_cnt_next = '0;
                w_state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_i) begin
                    if (r_idx < 3'd6) begin
                        w_idx_next     = w_idx_inc;
                        w_tx_data_next = w_frame[w_idx_inc];
                        w_state_next   = ST_SEND;
                    end else begin
                        w_frame_done_next = 1'b1;
                        w_seq_next        = r_seq + 8'd1;
                        w_state_next      = ST_IDLE;
                    end
                end else if (r_wait_cnt == LP_TIMEOUT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 32'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_idx        <= 3'd0;
            r_wait_cnt   <= '0;
            r_seq        <= 8'd0;
            r_tx_data    <= 8'd0;
            r_frame_done <= 1'b0;
            r_alert_prev <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pending    <= w_pending_next;
            r_idx        <= w_idx_next;
            r_wait_cnt   <= w_wait_cnt_next;
            r_seq        <= w_seq_next;
            r_tx_data    <= w_tx_data_next;
            r_frame_done <= w_frame_done_next;
            r_alert_prev <= status_i[1];
        end
    end

    // Snapshot capture of inputs and sequence number at frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_seq    <= 8'd0;
            r_snap_temp   <= 8'd0;
            r_snap_win    <= 4'd0;
            r_snap_door   <= 4'd0;
            r_snap_person <= 4'd0;
            r_snap_status <= 6'd0;
        end else if (w_capture) begin
            r_snap_seq    <= r_seq;
            r_snap_temp   <= temperature_i;
            r_snap_win    <= window_i;
            r_snap_door   <= door_i;
            r_snap_person <= person_i;
            r_snap_status <= status_i;
        end
    end

    assign tx_send_o    = (r_state == ST_SEND);
    assign tx_data_o    = r_tx_data;
    assign busy_o       = (r_state != ST_IDLE);
    assign frame_done_o = r_frame_done;
    assign timeout_o    = w_timeout;
    assign seq_o        = r_seq;

endmodule

// File: tb/tb_status_telemetry_tx.sv
// Directed bench for status_telemetry_tx: one instance with a long period for
// request/alert/timeout/reset cases, and one with a 100-cycle period for the
// periodic tick and sequence wrap.
module tb_status_telemetry_tx;

    logic       clk;
    logic       reset, enable, req, tx_done;
    logic [7:0] temp;
    logic [3:0] win, door, person;
    logic [5:0] status;
    logic       tx_send, busy, frame_done, timeout;
    logic [7:0] tx_data, seq;

    logic       p_reset, p_enable, p_req, p_tx_done;
    logic [5:0] p_status;
    logic       p_tx_send, p_busy, p_frame_done, p_timeout;
    logic [7:0] p_tx_data, p_seq;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] q_data [$];
    int         q_cyc  [$];
    int         fd_q   [$];
    int         fd_cnt = 0;
    int         to_cnt = 0;
    int         to_cyc = 0;
    int         u_cnt  = 0;
    logic       withhold = 1'b0;

    int         p_sends = 0;
    int         p_ucnt  = 0;
    int         p_start_q [$];
    logic [7:0] p_seq_q   [$];

    int t_req, t_en, t_rel, base;

    status_telemetry_tx #(
        .PERIOD_CYCLES (50_000),
        .TIMEOUT_CYCLES(50),
        .SOF           (8'hA5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable),
        .req_i        (req),
        .temperature_i(temp),
        .window_i     (win),
        .door_i       (door),
        .person_i     (person),
        .status_i     (status),
        .tx_send_o    (tx_send),
        .tx_data_o    (tx_data),
        .tx_done_i    (tx_done),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .timeout_o    (timeout),
        .seq_o        (seq)
    );

    status_telemetry_tx #(
        .PERIOD_CYCLES (100),
        .TIMEOUT_CYCLES(50),
        .SOF           (8'hA5)
    ) dut_p (
        .clk          (clk),
        .reset        (p_reset),
        .enable_i     (p_enable),
        .req_i        (p_req),
        .temperature_i(temp),
        .window_i     (win),
        .door_i       (door),
        .person_i     (person),
        .status_i     (p_status),
        .tx_send_o    (p_tx_send),
        .tx_data_o    (p_tx_data),
        .tx_done_i    (p_tx_done),
        .busy_o       (p_busy),
        .frame_done_o (p_frame_done),
        .timeout_o    (p_timeout),
        .seq_o        (p_seq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // UART models: done pulse 5 cycles after each send
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (u_cnt > 0) begin
                u_cnt--;
                if (u_cnt == 0) tx_done = 1'b1;
            end
            if (tx_send && !withhold) u_cnt = 5;
        end
    end

    initial begin
        p_tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            p_tx_done = 1'b0;
            if (p_ucnt > 0) begin
                p_ucnt--;
                if (p_ucnt == 0) p_tx_done = 1'b1;
            end
            if (p_tx_send) p_ucnt = 5;
        end
    end

    // Monitors: record sent bytes, frame_done and timeout pulses
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_send) begin
                q_data.push_back(tx_data);
                q_cyc.push_back(cyc);
                $display("tx byte cyc=%0d data=%02h", cyc, tx_data);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_q.push_back(cyc);
            end
            if (timeout) begin
                to_cnt++;
                to_cyc = cyc;
                $display("tx timeout cyc=%0d", cyc);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (p_tx_send) begin
                if (p_sends % 7 == 0) p_start_q.push_back(cyc);
                if (p_sends % 7 == 1) begin
                    p_seq_q.push_back(p_tx_data);
                    $display("periodic frame start=%0d seq=%02h", p_start_q[p_start_q.size()-1], p_tx_data);
                end
                p_sends++;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; req = 1'b0;
        temp = 8'h19; win = 4'h3; door = 4'h1; person = 4'h2; status = 6'b100100;
        p_reset = 1'b1; p_enable = 1'b1; p_req = 1'b0; p_status = 6'd0;
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_send", tx_send, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_seq", seq, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_to", timeout, 0);
        reset = 1'b0;

        // Test 1: request, frame A5 00 19 31 29 00 01 (0x19^0x31^0x29 = 0x01)
        step(10);
        req = 1'b1; t_req = cyc;
        step(1);
        req = 1'b0;
        // Test 2: second request during byte 3 of the first frame
        for (int i = 0; i < 100 && q_data.size() < 4; i++) step(1);
        req = 1'b1;
        step(1);
        req = 1'b0;
        for (int i = 0; i < 200 && fd_cnt < 1; i++) step(1);
        chk("t1_fd_cnt", fd_cnt, 1);
        chk("t1_seq", seq, 1);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_latency", q_cyc[0], t_req + 1);
        chk("t1_b0", q_data[0], 8'hA5);
        chk("t1_b1", q_data[1], 8'h00);
        chk("t1_b2", q_data[2], 8'h19);
        chk("t1_b3", q_data[3], 8'h31);
        chk("t1_b4", q_data[4], 8'h29);
        chk("t1_b5", q_data[5], 8'h00);
        chk("t1_b6", q_data[6], 8'h01);
        chk("t1_spacing", q_cyc[1] - q_cyc[0], 6);
        for (int i = 0; i < 200 && fd_cnt < 2; i++) step(1);
        chk("t2_fd_cnt", fd_cnt, 2);
        chk("t2_start", q_cyc[7], fd_q[0] + 1);
        chk("t2_b0", q_data[7], 8'hA5);
        chk("t2_b1", q_data[8], 8'h01);
        chk("t2_b6", q_data[13], 8'h00);
        chk("t2_seq", seq, 2);
        step(30);
        chk("t2_no_extra", q_data.size(), 14);

        // Test 5: alert rises while disabled, frame starts once enabled
        enable = 1'b0;
        status = 6'b000010;
        step(10);
        chk("t5_no_send", q_data.size(), 14);
        chk("t5_idle", busy, 0);
        enable = 1'b1; t_en = cyc;
        for (int i = 0; i < 10 && q_data.size() < 15; i++) step(1);
        chk("t5_latency", q_cyc[14], t_en + 1);
        for (int i = 0; i < 200 && fd_cnt < 3; i++) step(1);
        chk("t5_fd_cnt", fd_cnt, 3);
        chk("t5_b1", q_data[15], 8'h02);
        chk("t5_b4", q_data[18], 8'h20);
        chk("t5_b5", q_data[19], 8'h02);
        chk("t5_b6", q_data[20], 8'h08);

        // Test 4: done withheld after byte 2 send -> timeout 50 cycles later
        status = 6'd0;
        step(2);
        base = q_data.size();
        req = 1'b1;
        step(1);
        req = 1'b0;
        for (int i = 0; i < 50 && q_data.size() < base + 2; i++) step(1);
        withhold = 1'b1;
        for (int i = 0; i < 200 && to_cnt < 1; i++) step(1);
        chk("t4_to_cnt", to_cnt, 1);
        chk("t4_to_time", to_cyc, q_cyc[base + 2] + 50);
        chk("t4_bytes", q_data.size(), base + 3);
        step(1);
        chk("t4_busy", busy, 0);
        chk("t4_seq", seq, 3);
        chk("t4_no_fd", fd_cnt, 3);
        withhold = 1'b0;
        step(5);

        // Test 6: reset during byte 4
        base = q_data.size();
        req = 1'b1;
        step(1);
        req = 1'b0;
        for (int i = 0; i < 100 && q_data.size() < base + 5; i++) step(1);
        chk("t6_reached_b4", q_data.size(), base + 5);
        reset = 1'b1;
        step(1);
        chk("t6_send", tx_send, 0);
        chk("t6_data", tx_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_seq", seq, 0);
        chk("t6_fd", frame_done, 0);
        chk("t6_to", timeout, 0);
        reset = 1'b0;
        step(80);
        chk("t6_no_send", q_data.size(), base + 5);
        chk("t6_fd_cnt", fd_cnt, 3);
        chk("t6_to_cnt", to_cnt, 1);

        // Test 3: periodic frames every 100 cycles, seq wraps after 0xFF
        p_reset = 1'b0; t_rel = cyc;
        for (int i = 0; i < 30000 && p_seq_q.size() < 257; i++) step(1);
        chk("t3_frames", p_seq_q.size(), 257);
        chk("t3_first_start", p_start_q[0], t_rel + 100);
        chk("t3_period", p_start_q[1] - p_start_q[0], 100);
        chk("t3_period_late", p_start_q[256] - p_start_q[255], 100);
        chk("t3_seq0", p_seq_q[0], 8'h00);
        chk("t3_seq255", p_seq_q[255], 8'hFF);
        chk("t3_seq_wrap", p_seq_q[256], 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
